conv_result_streamer: RTL and testbench

- Consumer end of the convolution engine's packed result interface.
- On each new convolution completion, captures the flat OUTPUT_DIM*OUTPUT_DIM result vector into a shadow register.
- Serialises the captured elements one per handshake on a valid/ready stream, in row-major order, with index and last markers.
- Tracks the running maximum and its index for the downstream classifier stage.

---
 rtl/conv_result_streamer.sv | 168 ++++++++++++++++
 tb/tb_conv_result_streamer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
// Captures a completed convolution result map and streams its elements out in row-major
// order on a valid/ready channel, tracking the largest element for the classifier.
module conv_result_streamer #(
    parameter int unsigned OUTPUT_DIM  = 2,
    parameter int unsigned OUTBITWIDTH = 25,
    parameter int unsigned IDX_BIT     = 4
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          done_in,
    input  logic [OUTPUT_DIM*OUTPUT_DIM*OUTBITWIDTH-1:0]  result_in,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [OUTBITWIDTH-1:0]                        m_data,
    output logic [IDX_BIT-1:0]                            m_index,
    output logic                                          m_last,
    output logic                                          busy,
    output logic [OUTBITWIDTH-1:0]                        max_value,
    output logic [IDX_BIT-1:0]                            max_index,
    output logic                                          max_valid,
    output logic                                          overrun
);

    localparam int unsigned N     = OUTPUT_DIM * OUTPUT_DIM;
    localparam int unsigned VEC_W = N * OUTBITWIDTH;
    localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                 state, state_nxt;
    logic                   done_d;
    logic [OUTBITWIDTH-1:0] shadow     [N];
    logic [OUTBITWIDTH-1:0] shadow_nxt [N];
    logic [OUTBITWIDTH-1:0] res_elem   [N];
    logic [OUTBITWIDTH-1:0] run_max, run_max_nxt;
    logic [IDX_BIT-1:0]     run_idx, run_idx_nxt;

    logic                   m_valid_nxt, m_last_nxt, busy_nxt;
    logic [OUTBITWIDTH-1:0] m_data_nxt;
    logic [IDX_BIT-1:0]     m_index_nxt;
    logic [OUTBITWIDTH-1:0] max_value_nxt;
    logic [IDX_BIT-1:0]     max_index_nxt;
    logic                   max_valid_nxt, overrun_nxt;

    logic                   start_c;
    logic [IDX_BIT-1:0]     next_idx_c;
    logic [OUTBITWIDTH-1:0] next_elem_c;
    logic                   better_c;
    logic [OUTBITWIDTH-1:0] best_val_c;
    logic [IDX_BIT-1:0]     best_idx_c;

    // Unpack the flat result vector; element 0 sits at the MSB end.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign res_elem[g] = result_in[VEC_W-1-g*OUTBITWIDTH -: OUTBITWIDTH];
    end

    assign start_c = done_in & ~done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            done_d    <= 1'b1;
            shadow    <= '{default: '0};
            run_max   <= '0;
            run_idx   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            max_value <= '0;
            max_index <= '0;
            max_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_d    <= done_in;
            shadow    <= shadow_nxt;
            run_max   <= run_max_nxt;
            run_idx   <= run_idx_nxt;
            m_valid   <= m_valid_nxt;
            m_data    <= m_data_nxt;
            m_index   <= m_index_nxt;
            m_last    <= m_last_nxt;
            busy      <= busy_nxt;
            max_value <= max_value_nxt;
            max_index <= max_index_nxt;
            max_valid <= max_valid_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state and next-output logic; m_index doubles as the element counter.
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        run_max_nxt   = run_max;
        run_idx_nxt   = run_idx;
        m_valid_nxt   = m_valid;
        m_data_nxt    = m_data;
        m_index_nxt   = m_index;
        m_last_nxt    = m_last;
        busy_nxt      = busy;
        max_value_nxt = max_value;
        max_index_nxt = max_index;
        max_valid_nxt = max_valid;
        overrun_nxt   = overrun;

        next_idx_c  = m_index + IDX_BIT'(1);
        next_elem_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (next_idx_c == IDX_BIT'(i)) begin
                next_elem_c = shadow[i];
            end
        end

        // Strict compare so ties keep the earlier index.
        better_c   = (m_data > run_max);
        best_val_c = better_c ? m_data : run_max;
        best_idx_c = better_c ? m_index : run_idx;

        case (state)
            S_IDLE: begin
                if (start_c) begin
                    shadow_nxt    = res_elem;
                    run_max_nxt   = '0;
                    run_idx_nxt   = '0;
                    max_valid_nxt = 1'b0;
                    m_valid_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    m_data_nxt    = res_elem[0];
                    m_index_nxt   = '0;
                    m_last_nxt    = (LAST_IDX == '0);
                    state_nxt     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (start_c) begin
                    overrun_nxt = 1'b1;
                end
                if (m_ready) begin
                    run_max_nxt = best_val_c;
                    run_idx_nxt = best_idx_c;
                    if (m_index == LAST_IDX) begin
                        max_value_nxt = best_val_c;
                        max_index_nxt = best_idx_c;
                        max_valid_nxt = 1'b1;
                        m_valid_nxt   = 1'b0;
                        m_last_nxt    = 1'b0;
                        busy_nxt      = 1'b0;
                        state_nxt     = S_IDLE;
                    end else begin
                        m_index_nxt = next_idx_c;
                        m_data_nxt  = next_elem_c;
                        m_last_nxt  = (next_idx_c == LAST_IDX);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized and directed bench for conv_result_streamer against a stream-level reference model.
module tb_conv_result_streamer;

    localparam int unsigned D  = 2;
    localparam int unsigned W  = 25;
    localparam int unsigned IB = 4;
    localparam int unsigned N  = D * D;
    localparam int unsigned VW = N * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          done_in;
    logic [VW-1:0] result_in;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [IB-1:0] m_index;
    logic          m_last;
    logic          busy;
    logic [W-1:0]  max_value;
    logic [IB-1:0] max_index;
    logic          max_valid;
    logic          overrun;

    conv_result_streamer #(.OUTPUT_DIM(D), .OUTBITWIDTH(W), .IDX_BIT(IB)) dut (
        .clk(clk), .reset_n(reset_n), .done_in(done_in), .result_in(result_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .max_value(max_value), .max_index(max_index),
        .max_valid(max_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] el(input logic [VW-1:0] v, input int k);
        return v[VW-1-k*W -: W];
    endfunction

    // Reference model: a captured list of elements, a read position and derived flags.
    logic [W-1:0] mv [N];
    int           mpos;
    bit           mstream, mmaxvalid, mover, mprev, mst;
    logic [W-1:0] mmax;
    int           midx;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstream = 0; mpos = 0; mmaxvalid = 0; mover = 0; mprev = 1;
            mmax = '0; midx = 0;
        end else begin
            mst   = done_in && !mprev;
            mprev = done_in;
            if (mstream) begin
                if (mst) mover = 1;
                if (m_ready) begin
                    if (mpos == N - 1) begin
                        mmax = mv[0];
                        midx = 0;
                        for (int k = 1; k < N; k++) begin
                            if (mv[k] > mmax) begin
                                mmax = mv[k];
                                midx = k;
                            end
                        end
                        mmaxvalid = 1;
                        mstream   = 0;
                    end else begin
                        mpos++;
                    end
                end
            end else if (mst) begin
                for (int k = 0; k < N; k++) mv[k] = el(result_in, k);
                mpos      = 0;
                mstream   = 1;
                mmaxvalid = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("m_valid", 32'(m_valid), 32'(mstream));
            check("busy", 32'(busy), 32'(mstream));
            check("overrun", 32'(overrun), 32'(mover));
            check("max_valid", 32'(max_valid), 32'(mmaxvalid));
            if (mstream) begin
                check("m_data", 32'(m_data), 32'(mv[mpos]));
                check("m_index", 32'(m_index), 32'(mpos));
                check("m_last", 32'(m_last), 32'(mpos == N - 1));
            end else begin
                check("m_last_idle", 32'(m_last), 32'(0));
            end
            if (mmaxvalid) begin
                check("max_value", 32'(max_value), 32'(mmax));
                check("max_index", 32'(max_index), 32'(midx));
            end
        end
    end

    // Record accepted elements for the directed literal checks.
    logic [W-1:0] acc [$];
    always @(posedge clk) begin
        if (reset_n && m_valid && m_ready) acc.push_back(m_data);
    end

    task automatic kick(input logic [VW-1:0] v);
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        acc.delete();
        result_in = v;
        done_in   = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(!busy && max_valid) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout busy=%0d required=0", busy);
        end
    endtask

    task automatic check_acc(input string name, input logic [VW-1:0] v);
        check({name, "_count"}, 32'(acc.size()), 32'(N));
        for (int k = 0; k < N; k++) begin
            if (k < acc.size()) check(name, 32'(acc[k]), 32'(el(v, k)));
        end
    endtask

    logic [VW-1:0] vec_a, vec_b;

    initial begin
        vec_a = {25'd10, 25'd300, 25'd7, 25'd300};
        vec_b = {25'd1, 25'd2, 25'd3, 25'd4};
        reset_n   = 1'b0;
        done_in   = 1'b0;
        m_ready   = 1'b0;
        result_in = '0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_max_valid", 32'(max_valid), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_max_value", 32'(max_value), 32'(0));
        reset_n = 1'b1;

        // Basic stream with tie on the maximum.
        m_ready = 1'b1;
        kick(vec_a);
        check("t1_first_valid", 32'(m_valid), 32'(1));
        check("t1_first_data", 32'(m_data), 32'(10));
        check("t1_first_index", 32'(m_index), 32'(0));
        wait_done();
        check_acc("t1_acc", vec_a);
        check("t1_max_value", 32'(max_value), 32'(300));
        check("t1_max_index", 32'(max_index), 32'(1));
        check("t1_max_valid", 32'(max_valid), 32'(1));
        check("t1_busy", 32'(busy), 32'(0));

        // Backpressure while index 1 is presented.
        m_ready = 1'b1;
        kick(vec_a);
        @(negedge clk);
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_index", 32'(m_index), 32'(1));
            check("t2_hold_data", 32'(m_data), 32'(300));
        end
        m_ready = 1'b1;
        wait_done();
        check_acc("t2_acc", vec_a);

        // Back-to-back second stream with ascending values.
        kick(vec_b);
        check("t6_max_valid_low", 32'(max_valid), 32'(0));
        wait_done();
        check_acc("t6_acc", vec_b);
        check("t6_max_value", 32'(max_value), 32'(4));
        check("t6_max_index", 32'(max_index), 32'(3));

        // All-zero map.
        kick('0);
        wait_done();
        check_acc("t5_acc", '0);
        check("t5_max_value", 32'(max_value), 32'(0));
        check("t5_max_index", 32'(max_index), 32'(0));
        check("t5_max_valid", 32'(max_valid), 32'(1));

        // Completion arriving mid-stream sets overrun and does not disturb the stream.
        m_ready = 1'b0;
        kick(vec_a);
        check("t3_overrun_before", 32'(overrun), 32'(0));
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        result_in = vec_b;
        done_in   = 1'b1;
        @(negedge clk);
        check("t3_overrun_set", 32'(overrun), 32'(1));
        m_ready = 1'b1;
        wait_done();
        check_acc("t3_acc", vec_a);
        check("t3_overrun_sticky", 32'(overrun), 32'(1));

        // Reset mid-stream with done_in held high.
        m_ready = 1'b1;
        kick(vec_a);
        @(negedge clk);
        @(negedge clk);
        check("t4_index_before_rst", 32'(m_index), 32'(2));
        #2 reset_n = 1'b0;
        #1;
        check("t4_rst_m_valid", 32'(m_valid), 32'(0));
        check("t4_rst_busy", 32'(busy), 32'(0));
        check("t4_rst_overrun", 32'(overrun), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_no_restream_valid", 32'(m_valid), 32'(0));
            check("t4_no_restream_busy", 32'(busy), 32'(0));
        end
        kick(vec_b);
        wait_done();
        check_acc("t4_acc", vec_b);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) done_in = ~done_in;
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < N; k++) begin
                    result_in[VW-1-k*W -: W] = ($urandom_range(0, 1) != 0) ?
                        W'($urandom_range(0, 3)) : W'($urandom);
                end
            end
        end
        m_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
